// File: rtl/trigger_frame_builder_pkg.sv
// Shared definitions for the trigger frame builder.
//   - frame word markers and footer flag bit positions
//   - FSM state type
//   - lane_xor(): 32-bit XOR fold of one 128-bit data word (used by the
//     optional footer checksum, enabled with FRAME_CHECKSUM_EN)
// Reuses `RFDC_TDATA_WIDTH when the surrounding build defines it.

`ifndef RFDC_TDATA_WIDTH
`define RFDC_TDATA_WIDTH 128
`endif

package trigger_frame_builder_pkg;

  localparam int unsigned TdataWidth = `RFDC_TDATA_WIDTH;

  localparam logic [7:0] HeaderMarker = 8'hAA;
  localparam logic [7:0] FooterMarker = 8'h55;

  // Footer flag bit positions
  localparam int unsigned FtrSatBit   = 111;
  localparam int unsigned FtrTruncBit = 110;
  localparam int unsigned FtrOvfBit   = 109;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StWaitLow
  } frame_state_e;

  function automatic logic [31:0] lane_xor(input logic [127:0] w);
    return w[31:0] ^ w[63:32] ^ w[95:64] ^ w[127:96];
  endfunction

endpackage

// File: rtl/trigger_frame_builder_frame_sync_fifo.sv
// frame_sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high clear (pointers and count)
//   wr_en_i     write request; accepted when not full or when a read fires
//   wr_data_i   write word
//   rd_ready_i  consumer ready; a read fires on rd_valid_o & rd_ready_i
//   rd_data_o   head-of-queue word (valid whenever rd_valid_o is high)
//   rd_valid_o  FIFO non-empty
//   free_o      number of free entries
// Depth must be a power of two so the pointers wrap naturally.

module frame_sync_fifo #(
  parameter int unsigned Width = 129,
  parameter int unsigned Depth = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [Width-1:0]           wr_data_i,
  input  logic                       rd_ready_i,
  output logic [Width-1:0]           rd_data_o,
  output logic                       rd_valid_o,
  output logic [$clog2(Depth):0]     free_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             rd_fire, wr_fire, full;

  assign full       = (cnt_q == CntW'(Depth));
  assign rd_valid_o = (cnt_q != '0);
  assign rd_fire    = rd_valid_o & rd_ready_i;
  // A read in the same cycle frees the slot, so a write at full is still legal.
  assign wr_fire    = wr_en_i & (~full | rd_fire);
  assign rd_data_o  = mem_q[rptr_q];
  assign free_o     = CntW'(Depth) - cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_fire) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_fire) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({wr_fire, rd_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/trigger_frame_builder.sv
// trigger_frame_builder: packs each trigger window of the selected-gain ADC
// stream into an AXI4-Stream frame (header, up to MAX_FRAME_WORDS data words,
// footer) buffered in an FWFT FIFO so the downstream side may backpressure.
// Ports:
//   ACLK, ARESET        clock, synchronous active-high reset
//   SET_CONFIG          synchronous clear, same effect as ARESET
//   STOP                blocks new frames; a frame in progress completes
//   CHANNEL_ID          channel number for header/footer
//   TIMESTAMP           time counter sampled at frame start
//   S_AXIS_TDATA/TVALID sample stream, cycle-aligned with TRIGGER
//   TRIGGER             acquisition window
//   SATURATION_FLAG     1 = low-gain path selected
//   M_AXIS_*            frame output stream (TLAST on footer)
//   DROP_COUNT          frames rejected for lack of FIFO space (saturating)
// Optional: define FRAME_CHECKSUM_EN to place a 32-bit XOR of all data-word
// lanes in footer [47:16]; otherwise those bits are zero.

module trigger_frame_builder
  import trigger_frame_builder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 64,
  parameter int unsigned MAX_FRAME_WORDS = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  SET_CONFIG,
  input  logic                  STOP,
  input  logic [7:0]            CHANNEL_ID,
  input  logic [63:0]           TIMESTAMP,
  input  logic [TdataWidth-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  input  logic                  TRIGGER,
  input  logic                  SATURATION_FLAG,
  output logic [TdataWidth-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic [15:0]           DROP_COUNT
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic clr;
  assign clr = ARESET | SET_CONFIG;

  // Input register stage
  logic                  trig_q;
  logic [TdataWidth-1:0] data_q;
  logic                  sat_q;

  always_ff @(posedge ACLK) begin
    if (clr) begin
      trig_q <= 1'b0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      trig_q <= TRIGGER & S_AXIS_TVALID;
      data_q <= S_AXIS_TDATA;
      sat_q  <= SATURATION_FLAG;
    end
  end

  frame_state_e state_q, state_d;
  logic [15:0]  word_cnt_q, word_cnt_d;
  logic         sat_seen_q, sat_seen_d;
  logic [31:0]  frame_idx_q, frame_idx_d;
  logic [15:0]  drop_cnt_q, drop_cnt_d;
  logic [31:0]  csum_field;

  logic                  wr_en;
  logic [TdataWidth:0]   wr_data;
  logic [TdataWidth:0]   rd_data;
  logic                  rd_valid;
  logic [CntW-1:0]       free;
  logic                  start;
  logic [TdataWidth-1:0] header_word;
  logic [TdataWidth-1:0] footer_word;

`ifdef FRAME_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
  assign csum_field = csum_q;
`else
  assign csum_field = 32'h0;
`endif

  assign start = TRIGGER & S_AXIS_TVALID & ~STOP;

  assign header_word = {HeaderMarker, CHANNEL_ID, SATURATION_FLAG, 15'h0,
                        frame_idx_q, TIMESTAMP};
  // Flags are zero here and OR-ed in per termination reason.
  assign footer_word = {FooterMarker, CHANNEL_ID, sat_seen_q, 2'b00, 13'h0,
                        frame_idx_q, 16'h0, csum_field, word_cnt_q};

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    sat_seen_d  = sat_seen_q;
    frame_idx_d = frame_idx_q;
    drop_cnt_d  = drop_cnt_q;
    wr_en       = 1'b0;
    wr_data     = '0;
`ifdef FRAME_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (free >= CntW'(3)) begin
            wr_en      = 1'b1;
            wr_data    = {1'b0, header_word};
            word_cnt_d = '0;
            sat_seen_d = 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_d     = '0;
`endif
            state_d    = StData;
          end else begin
            if (drop_cnt_q != 16'hFFFF) begin
              drop_cnt_d = drop_cnt_q + 16'd1;
            end
            state_d = StWaitLow;
          end
        end
      end

      StData: begin
        if (!trig_q) begin
          wr_en       = 1'b1;
          wr_data     = {1'b1, footer_word};
          frame_idx_d = frame_idx_q + 32'd1;
          state_d     = StIdle;
        end else if (word_cnt_q == 16'(MAX_FRAME_WORDS)) begin
          wr_en                = 1'b1;
          wr_data              = {1'b1, footer_word};
          wr_data[FtrTruncBit] = 1'b1;
          frame_idx_d          = frame_idx_q + 32'd1;
          state_d              = StWaitLow;
        end else if (free >= CntW'(2)) begin
          wr_en      = 1'b1;
          wr_data    = {1'b0, data_q};
          word_cnt_d = word_cnt_q + 16'd1;
          sat_seen_d = sat_seen_q | sat_q;
`ifdef FRAME_CHECKSUM_EN
          csum_d     = csum_q ^ lane_xor(data_q);
`endif
        end else begin
          // Last free slot was reserved for this footer.
          wr_en              = 1'b1;
          wr_data            = {1'b1, footer_word};
          wr_data[FtrOvfBit] = 1'b1;
          frame_idx_d        = frame_idx_q + 32'd1;
          state_d            = StWaitLow;
        end
      end

      StWaitLow: begin
        if (!TRIGGER) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (clr) begin
      state_q     <= StIdle;
      word_cnt_q  <= '0;
      sat_seen_q  <= 1'b0;
      frame_idx_q <= '0;
      drop_cnt_q  <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      sat_seen_q  <= sat_seen_d;
      frame_idx_q <= frame_idx_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  frame_sync_fifo #(
    .Width (TdataWidth + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (ACLK),
    .rst_i      (clr),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .rd_ready_i (M_AXIS_TREADY),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .free_o     (free)
  );

  assign M_AXIS_TDATA  = rd_data[TdataWidth-1:0];
  assign M_AXIS_TVALID = rd_valid;
  // Gate with valid so stale memory never shows a TLAST after a flush.
  assign M_AXIS_TLAST  = rd_valid & rd_data[TdataWidth];
  assign DROP_COUNT    = drop_cnt_q;

endmodule

// File: tb/tb_trigger_frame_builder.sv
module tb_trigger_frame_builder;

  logic         ACLK = 1'b0;
  logic         ARESET, SET_CONFIG, STOP;
  logic [7:0]   CHANNEL_ID;
  logic [63:0]  TIMESTAMP;
  logic [127:0] S_AXIS_TDATA;
  logic         S_AXIS_TVALID, TRIGGER, SATURATION_FLAG;
  logic [127:0] M_AXIS_TDATA;
  logic         M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
  logic [15:0]  DROP_COUNT;

  localparam logic [7:0] Chan = 8'h3C;

  trigger_frame_builder #(
    .FIFO_DEPTH      (8),
    .MAX_FRAME_WORDS (16)
  ) dut (
    .ACLK            (ACLK),
    .ARESET          (ARESET),
    .SET_CONFIG      (SET_CONFIG),
    .STOP            (STOP),
    .CHANNEL_ID      (CHANNEL_ID),
    .TIMESTAMP       (TIMESTAMP),
    .S_AXIS_TDATA    (S_AXIS_TDATA),
    .S_AXIS_TVALID   (S_AXIS_TVALID),
    .TRIGGER         (TRIGGER),
    .SATURATION_FLAG (SATURATION_FLAG),
    .M_AXIS_TDATA    (M_AXIS_TDATA),
    .M_AXIS_TVALID   (M_AXIS_TVALID),
    .M_AXIS_TREADY   (M_AXIS_TREADY),
    .M_AXIS_TLAST    (M_AXIS_TLAST),
    .DROP_COUNT      (DROP_COUNT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [127:0] data;
    logic         last;
    int           tag;
  } exp_t;

  typedef struct {
    int          len;
    int          sat_at;
    bit          stop;
    logic [63:0] ts;
    int          exp_cnt;   // -1: no frame expected
    bit          trunc;
    bit          hsat;
    bit          seen;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   exp_idx = 0;
  int   tag_seq = 0;

  function automatic logic [127:0] pat(int v, int k);
    logic [31:0] w;
    w = {8'hD0, 8'(v), 16'(k)};
    return {w ^ 32'h5A5A_0F0F, ~w, w + 32'd7, w};
  endfunction

  function automatic logic [127:0] hdr(bit sat, int idx, logic [63:0] ts);
    return {8'hAA, Chan, sat, 15'h0, 32'(idx), ts};
  endfunction

  function automatic logic [127:0] ftr(bit seen, bit trunc, bit ovf, int idx,
                                       logic [31:0] csum, int cnt);
    return {8'h55, Chan, seen, trunc, ovf, 13'h0, 32'(idx), 16'h0, csum, 16'(cnt)};
  endfunction

  task automatic push(logic [127:0] d, logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    e.tag  = tag_seq;
    tag_seq++;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(string name, logic [127:0] got, logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard check of every accepted output word.
  always @(negedge ACLK) begin
    if (!ARESET && !SET_CONFIG && M_AXIS_TVALID && M_AXIS_TREADY) begin
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word: got %h last %b, expected nothing", M_AXIS_TDATA,
                 M_AXIS_TLAST);
      end else begin
        e = sb.pop_front();
        if (M_AXIS_TDATA !== e.data || M_AXIS_TLAST !== e.last) begin
          n_bad++;
          $display("FAIL word tag %0d: got %h last %b, expected %h last %b", e.tag,
                   M_AXIS_TDATA, M_AXIS_TLAST, e.data, e.last);
        end
      end
    end
  end

  // Pushes the expected frame, then drives the trigger window and a gap.
  task automatic run_frame(int v, int len, int sat_at, bit stop, logic [63:0] ts,
                           int exp_cnt, bit trunc, bit ovf, bit hsat, bit seen, int gap);
    logic [31:0]  csum;
    logic [127:0] d;
    csum = 32'h0;
    if (exp_cnt >= 0) begin
      push(hdr(hsat, exp_idx, ts), 1'b0);
      for (int k = 0; k < exp_cnt; k++) begin
        d = pat(v, k);
        push(d, 1'b0);
        csum = csum ^ d[31:0] ^ d[63:32] ^ d[95:64] ^ d[127:96];
      end
`ifndef FRAME_CHECKSUM_EN
      csum = 32'h0;
`endif
      push(ftr(seen, trunc, ovf, exp_idx, csum, exp_cnt), 1'b1);
      exp_idx++;
    end
    for (int k = 0; k < len; k++) begin
      TRIGGER         = 1'b1;
      S_AXIS_TVALID   = 1'b1;
      S_AXIS_TDATA    = pat(v, k);
      SATURATION_FLAG = (k == sat_at);
      STOP            = stop;
      TIMESTAMP       = (k == 0) ? ts : ts + 64'(k * 3);
      step();
    end
    TRIGGER         = 1'b0;
    S_AXIS_TVALID   = 1'b0;
    S_AXIS_TDATA    = '0;
    SATURATION_FLAG = 1'b0;
    STOP            = 1'b0;
    for (int k = 0; k < gap; k++) step();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    vecs[0] = '{len: 5,  sat_at: -1, stop: 0, ts: 64'h1234,      exp_cnt: 5,  trunc: 0,
                hsat: 0, seen: 0};
    vecs[1] = '{len: 20, sat_at: -1, stop: 0, ts: 64'h2000,      exp_cnt: 16, trunc: 1,
                hsat: 0, seen: 0};
    vecs[2] = '{len: 3,  sat_at: 1,  stop: 0, ts: 64'h3000,      exp_cnt: 3,  trunc: 0,
                hsat: 0, seen: 1};
    vecs[3] = '{len: 4,  sat_at: 0,  stop: 0, ts: 64'hFFFF_0000, exp_cnt: 4,  trunc: 0,
                hsat: 1, seen: 1};
    vecs[4] = '{len: 16, sat_at: -1, stop: 0, ts: 64'h5000,      exp_cnt: 16, trunc: 0,
                hsat: 0, seen: 0};
    vecs[5] = '{len: 17, sat_at: 16, stop: 0, ts: 64'h6000,      exp_cnt: 16, trunc: 1,
                hsat: 0, seen: 0};
    vecs[6] = '{len: 4,  sat_at: -1, stop: 1, ts: 64'h7000,      exp_cnt: -1, trunc: 0,
                hsat: 0, seen: 0};
    vecs[7] = '{len: 1,  sat_at: -1, stop: 0, ts: 64'h8000,      exp_cnt: 1,  trunc: 0,
                hsat: 0, seen: 0};

    ARESET = 1'b1;  SET_CONFIG = 1'b0; STOP = 1'b0; CHANNEL_ID = Chan;
    TIMESTAMP = '0; S_AXIS_TDATA = '0; S_AXIS_TVALID = 1'b0; TRIGGER = 1'b0;
    SATURATION_FLAG = 1'b0; M_AXIS_TREADY = 1'b1;
    repeat (3) step();
    check("reset_tvalid", 128'(M_AXIS_TVALID), 128'(0));
    check("reset_tlast", 128'(M_AXIS_TLAST), 128'(0));
    check("reset_drop", 128'(DROP_COUNT), 128'(0));
    ARESET = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_frame(i, vecs[i].len, vecs[i].sat_at, vecs[i].stop, vecs[i].ts, vecs[i].exp_cnt,
                vecs[i].trunc, 1'b0, vecs[i].hsat, vecs[i].seen, 4);
    end
    wait_drain();
    check("drop_after_table", 128'(DROP_COUNT), 128'(0));

    // Overflow: stalled sink, depth 8 -> header + 6 words + overflow footer.
    M_AXIS_TREADY = 1'b0;
    run_frame(20, 12, -1, 1'b0, 64'h9000, 6, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    check("stall_valid", 128'(M_AXIS_TVALID), 128'(1));
    check("stall_data0", M_AXIS_TDATA, sb[0].data);
    check("stall_last0", 128'(M_AXIS_TLAST), 128'(0));
    // FIFO full: this frame is dropped.
    run_frame(21, 3, -1, 1'b0, 64'hA000, -1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    check("drop_count_1", 128'(DROP_COUNT), 128'(1));
    check("stall_data1", M_AXIS_TDATA, sb[0].data);
    M_AXIS_TREADY = 1'b1;
    wait_drain();
    check("drop_count_kept", 128'(DROP_COUNT), 128'(1));

    // ARESET mid-frame with words queued.
    M_AXIS_TREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      TRIGGER = 1'b1; S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = pat(30, k);
      step();
    end
    check("pre_reset_valid", 128'(M_AXIS_TVALID), 128'(1));
    ARESET = 1'b1; TRIGGER = 1'b0; S_AXIS_TVALID = 1'b0;
    step();
    check("areset_tvalid", 128'(M_AXIS_TVALID), 128'(0));
    check("areset_tlast", 128'(M_AXIS_TLAST), 128'(0));
    check("areset_drop", 128'(DROP_COUNT), 128'(0));
    ARESET = 1'b0; M_AXIS_TREADY = 1'b1;
    sb.delete();
    exp_idx = 0;
    step();
    run_frame(31, 2, -1, 1'b0, 64'hB000, 2, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    wait_drain();

    // SET_CONFIG clears the frame index as well.
    SET_CONFIG = 1'b1;
    step();
    SET_CONFIG = 1'b0;
    exp_idx = 0;
    step();
    run_frame(32, 1, -1, 1'b0, 64'hC000, 1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
